// File: rtl/axis_route_pkg.sv
// axis_route_pkg: shared types, default widths and helpers for the
// AXI-Stream demux routing controller.
//
// This package is used in every build. The per-channel PMU counters that use
// sat_inc() exist only when ROUTE_PMU_EN is defined.

package axis_route_pkg;

  // Defaults applied when the NoC port does not override the parameters.
  localparam int ROUTE_CHANNELS_DEF = 5;
  localparam int ROUTE_DEST_W_DEF   = 4;
  localparam int ROUTE_DEFAULT_CH   = 0;
  localparam int ROUTE_CNT_W_DEF    = 32;

  // Widest counter that sat_inc() handles.
  localparam int ROUTE_SAT_W_MAX    = 64;

  // Two-state routing FSM. ROUTE_ACTIVE means the demux is held on a channel.
  typedef enum logic [0:0] {
    ROUTE_IDLE   = 1'b0,
    ROUTE_ACTIVE = 1'b1
  } route_state_e;

  // Increment that sticks at the all-ones value of a 'width'-bit counter.
  // The counter value is passed in zero-extended to 64 bits.
  function automatic logic [63:0] sat_inc(input logic [63:0] val,
                                          input int unsigned width);
    logic [63:0] lim;
    lim = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (val >= lim) ? lim : (val + 64'd1);
  endfunction

endpackage

// File: rtl/axis_route_pmu.sv
// axis_route_pmu: per-channel saturating packet and beat counters for the
// routing controller's performance-monitor view.
//
// The top level instantiates this module only when ROUTE_PMU_EN is defined.
// A synchronous clear takes priority over an increment in the same cycle.
// Both counter banks leave the module as flat vectors. Channel c occupies
// bits [c*CNT_WIDTH +: CNT_WIDTH].

module axis_route_pmu
  import axis_route_pkg::*;
#(
  parameter int CHANNEL_NUMBER       = ROUTE_CHANNELS_DEF,
  parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER),
  parameter int CNT_WIDTH            = ROUTE_CNT_W_DEF
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                beat,
  input  logic                                last,
  input  logic [CHANNEL_NUMBER_WIDTH-1:0]     ch,
  input  logic                                clear,
  output logic [CNT_WIDTH*CHANNEL_NUMBER-1:0] pkt_cnt,
  output logic [CNT_WIDTH*CHANNEL_NUMBER-1:0] beat_cnt
);

  if (CNT_WIDTH > ROUTE_SAT_W_MAX) begin : g_bad_width
    $error("axis_route_pmu: CNT_WIDTH wider than sat_inc supports");
  end

  for (genvar g = 0; g < CHANNEL_NUMBER; g++) begin : g_ch
    logic                 w_hit;
    logic [CNT_WIDTH-1:0] r_beat;
    logic [CNT_WIDTH-1:0] r_pkt;

    assign w_hit = beat && (ch == CHANNEL_NUMBER_WIDTH'(g));

    // Count beats on this channel, plus packets when the beat carries TLAST.
    // A clear overrides both counts.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_beat <= '0;
        r_pkt  <= '0;
      end else if (clear) begin
        r_beat <= '0;
        r_pkt  <= '0;
      end else if (w_hit) begin
        r_beat <= CNT_WIDTH'(sat_inc(64'(r_beat), CNT_WIDTH));
        if (last) begin
          r_pkt <= CNT_WIDTH'(sat_inc(64'(r_pkt), CNT_WIDTH));
        end
      end
    end

    assign beat_cnt[g*CNT_WIDTH +: CNT_WIDTH] = r_beat;
    assign pkt_cnt[g*CNT_WIDTH +: CNT_WIDTH]  = r_pkt;
  end

endmodule

// File: rtl/axis_demux_route_ctrl.sv
// axis_demux_route_ctrl: packet-level routing controller for the AXI-Stream
// channel demultiplexer in a NoC router port.
//
// The first TDEST of a packet selects a demux channel. The controller holds
// that channel until the TLAST handshake. en, ctrl, route_err and busy are all
// registered outputs.
//
// Optional feature: define ROUTE_PMU_EN to add per-channel packet and beat
// counters (pmu_pkt_cnt, pmu_beat_cnt, pmu_clear). With the macro undefined,
// those ports and counters are absent and routing behaves the same.
//
// state         | meaning
// --------------+-----------------------------------------------------------
// ROUTE_IDLE    | no packet in flight; en=0; ctrl keeps the last channel
// ROUTE_ACTIVE  | demux held on the latched channel until the TLAST beat

module axis_demux_route_ctrl
  import axis_route_pkg::*;
#(
  parameter int CHANNEL_NUMBER       = ROUTE_CHANNELS_DEF,
  parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER),
  parameter int DEST_WIDTH           = ROUTE_DEST_W_DEF,
  parameter int DEFAULT_CHANNEL      = ROUTE_DEFAULT_CH,
  parameter int CNT_WIDTH            = ROUTE_CNT_W_DEF
) (
  input  logic                                ACLK,
  input  logic                                ARESETn,
  input  logic                                in_tvalid,
  input  logic                                in_tready,
  input  logic                                in_tlast,
  input  logic [DEST_WIDTH-1:0]               in_tdest,
  output logic                                en,
  output logic [CHANNEL_NUMBER_WIDTH-1:0]     ctrl,
  output logic                                route_err,
  output logic                                busy
`ifdef ROUTE_PMU_EN
  ,
  output logic [CNT_WIDTH*CHANNEL_NUMBER-1:0] pmu_pkt_cnt,
  output logic [CNT_WIDTH*CHANNEL_NUMBER-1:0] pmu_beat_cnt,
  input  logic                                pmu_clear
`endif
);

  // The range check runs at a width that holds both TDEST and the channel
  // count. An over-range TDEST therefore cannot alias into a valid channel.
  localparam int CMP_W = (DEST_WIDTH > 31) ? (DEST_WIDTH + 1) : 32;

  if (CHANNEL_NUMBER < 2) begin : g_bad_channels
    $error("axis_demux_route_ctrl: CHANNEL_NUMBER must be at least 2");
  end
  if ((DEFAULT_CHANNEL < 0) || (DEFAULT_CHANNEL >= CHANNEL_NUMBER)) begin : g_bad_default
    $error("axis_demux_route_ctrl: DEFAULT_CHANNEL out of range");
  end

  route_state_e                    r_state;
  logic                            r_en;
  logic                            r_busy;
  logic                            r_err;
  logic [CHANNEL_NUMBER_WIDTH-1:0] r_ch;

  logic                            w_beat;
  logic                            w_in_range;
  logic [CHANNEL_NUMBER_WIDTH-1:0] w_dest_ch;

  // Only a beat accepted through the enabled demux counts as a handshake.
  assign w_beat     = in_tvalid & in_tready & r_en;
  assign w_in_range = (CMP_W'(in_tdest) < CMP_W'(CHANNEL_NUMBER));
  assign w_dest_ch  = w_in_range ? CHANNEL_NUMBER_WIDTH'(in_tdest)
                                 : CHANNEL_NUMBER_WIDTH'(DEFAULT_CHANNEL);

  // Routing FSM. Latch the channel from the first TVALID, then hold it until
  // the TLAST handshake. All outputs are updated here.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= ROUTE_IDLE;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_ch    <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ROUTE_IDLE: begin
          if (in_tvalid) begin
            r_ch    <= w_dest_ch;
            r_err   <= ~w_in_range;
            r_en    <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= ROUTE_ACTIVE;
          end
        end
        ROUTE_ACTIVE: begin
          // TDEST is ignored here. Bubbles (TVALID low) keep the route.
          if (w_beat && in_tlast) begin
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ROUTE_IDLE;
          end
        end
        default: begin
          r_en    <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ROUTE_IDLE;
        end
      endcase
    end
  end

  assign en        = r_en;
  assign ctrl      = r_ch;
  assign route_err = r_err;
  assign busy      = r_busy;

`ifdef ROUTE_PMU_EN
  axis_route_pmu #(
    .CHANNEL_NUMBER       (CHANNEL_NUMBER),
    .CHANNEL_NUMBER_WIDTH (CHANNEL_NUMBER_WIDTH),
    .CNT_WIDTH            (CNT_WIDTH)
  ) u_pmu (
    .clk      (ACLK),
    .rst_n    (ARESETn),
    .beat     (w_beat),
    .last     (in_tlast),
    .ch       (r_ch),
    .clear    (pmu_clear),
    .pkt_cnt  (pmu_pkt_cnt),
    .beat_cnt (pmu_beat_cnt)
  );
`endif

endmodule

// File: tb/tb_axis_demux_route_ctrl.sv
// tb_axis_demux_route_ctrl: bench for the demux routing controller.
//
// The bench drives whole packets (destination, length, handshake pattern).
// Its expectations come from packet-level rules:
// - the channel is the destination if it is in range, otherwise the default;
// - en rises one cycle after TVALID and falls one cycle after the TLAST beat;
// - PMU counts are handshakes per channel, capped at all-ones.
// The PMU checks are built only when ROUTE_PMU_EN is defined.

module tb_axis_demux_route_ctrl;

  localparam int CN  = 5;
  localparam int CNW = $clog2(CN);
  localparam int DW  = 4;
  localparam int DEF = 0;
  localparam int CW  = 6;

  logic           ACLK      = 1'b0;
  logic           ARESETn   = 1'b0;
  logic           in_tvalid = 1'b0;
  logic           in_tready = 1'b0;
  logic           in_tlast  = 1'b0;
  logic [DW-1:0]  in_tdest  = '0;
  logic           en;
  logic [CNW-1:0] ctrl;
  logic           route_err;
  logic           busy;
`ifdef ROUTE_PMU_EN
  logic [CW*CN-1:0] pmu_pkt_cnt;
  logic [CW*CN-1:0] pmu_beat_cnt;
  logic             pmu_clear = 1'b0;
`endif

  always #5 ACLK = ~ACLK;

  axis_demux_route_ctrl #(
    .CHANNEL_NUMBER       (CN),
    .CHANNEL_NUMBER_WIDTH (CNW),
    .DEST_WIDTH           (DW),
    .DEFAULT_CHANNEL      (DEF),
    .CNT_WIDTH            (CW)
  ) dut (
    .ACLK         (ACLK),
    .ARESETn      (ARESETn),
    .in_tvalid    (in_tvalid),
    .in_tready    (in_tready),
    .in_tlast     (in_tlast),
    .in_tdest     (in_tdest),
    .en           (en),
    .ctrl         (ctrl),
    .route_err    (route_err),
    .busy         (busy)
`ifdef ROUTE_PMU_EN
    ,
    .pmu_pkt_cnt  (pmu_pkt_cnt),
    .pmu_beat_cnt (pmu_beat_cnt),
    .pmu_clear    (pmu_clear)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  int exp_beat [CN];
  int exp_pkt  [CN];
  int last_ch  = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic int route_of(input int d);
    return (d < CN) ? d : DEF;
  endfunction

  function automatic longint sat(input int v);
    longint lim;
    lim = (longint'(1) << CW) - 1;
    return (longint'(v) > lim) ? lim : longint'(v);
  endfunction

  task automatic clear_model();
    for (int c = 0; c < CN; c++) begin
      exp_beat[c] = 0;
      exp_pkt[c]  = 0;
    end
  endtask

  task automatic check_pmu();
`ifdef ROUTE_PMU_EN
    for (int c = 0; c < CN; c++) begin
      check_val($sformatf("pmu_beat[%0d]", c), 64'(pmu_beat_cnt[c*CW +: CW]), 64'(sat(exp_beat[c])));
      check_val($sformatf("pmu_pkt[%0d]", c),  64'(pmu_pkt_cnt[c*CW +: CW]),  64'(sat(exp_pkt[c])));
    end
`endif
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge ACLK);
      check_val("idle_en", 64'(en), 64'(0));
      check_val("idle_busy", 64'(busy), 64'(0));
      in_tvalid = 1'b0;
      in_tlast  = 1'b0;
`ifdef ROUTE_PMU_EN
      pmu_clear = 1'b0;
`endif
    end
  endtask

  // mode 0: TVALID and TREADY held high; mode 1: TREADY toggles and TDEST
  // moves to 4 after the first beat; mode 2: random bubbles and stalls.
  // clr_beat: handshake index at which pmu_clear is pulsed (-1 for none).
  // abort_beat: reset is asserted once this many beats are done (-1 for none).
  task automatic send_pkt(input int dest, input int len, input int mode,
                          input int clr_beat, input int abort_beat);
    int  ch;
    int  done;
    int  cyc;
    bit  v;
    bit  r;
    bit  clr_pending;
    ch          = route_of(dest);
    done        = 0;
    cyc         = 0;
    clr_pending = 1'b0;

    @(negedge ACLK);
    check_val("pre_en", 64'(en), 64'(0));
    check_val("pre_busy", 64'(busy), 64'(0));
    check_val("hold_ctrl", 64'(ctrl), 64'(last_ch));
    in_tvalid = 1'b1;
    in_tdest  = DW'(dest);
    in_tlast  = (len == 1);
    in_tready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
`ifdef ROUTE_PMU_EN
    pmu_clear = 1'b0;
`endif

    while (done < len) begin
      @(negedge ACLK);
      cyc++;
      check_val("act_en", 64'(en), 64'(1));
      check_val("act_busy", 64'(busy), 64'(1));
      check_val("act_ctrl", 64'(ctrl), 64'(ch));
      check_val("route_err", 64'(route_err), 64'((cyc == 1) && (dest >= CN)));
      if (clr_pending) begin
        check_pmu();
        clr_pending = 1'b0;
      end
      last_ch = ch;

      if (abort_beat >= 0 && done == abort_beat) begin
        ARESETn = 1'b0;
        #1;
        check_val("rst_en", 64'(en), 64'(0));
        check_val("rst_ctrl", 64'(ctrl), 64'(0));
        check_val("rst_busy", 64'(busy), 64'(0));
        clear_model();
        last_ch   = 0;
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
`ifdef ROUTE_PMU_EN
        pmu_clear = 1'b0;
`endif
        check_pmu();
        @(negedge ACLK);
        ARESETn = 1'b1;
        return;
      end

      if (cyc > 40 * len + 20) begin
        check_val("pkt_timeout", 64'(1), 64'(0));
        break;
      end

      case (mode)
        0:       begin v = 1'b1; r = 1'b1; end
        1:       begin v = 1'b1; r = cyc[0]; end
        default: begin v = ($urandom_range(0, 3) != 0); r = ($urandom_range(0, 3) != 0); end
      endcase
      in_tvalid = v;
      in_tready = r;
      in_tlast  = (done == len - 1);
      in_tdest  = (mode == 1) ? DW'(4) : DW'($urandom);
`ifdef ROUTE_PMU_EN
      pmu_clear = 1'b0;
`endif
      if (v && r) begin
        exp_beat[ch]++;
        if (done == len - 1) exp_pkt[ch]++;
        if (done == clr_beat) begin
`ifdef ROUTE_PMU_EN
          pmu_clear = 1'b1;
`endif
          clear_model();
          clr_pending = 1'b1;
        end
        done++;
      end
    end
  endtask

  initial begin
    clear_model();
    ARESETn = 1'b0;
    repeat (2) @(negedge ACLK);
    check_val("reset_en", 64'(en), 64'(0));
    check_val("reset_ctrl", 64'(ctrl), 64'(0));
    check_val("reset_err", 64'(route_err), 64'(0));
    check_val("reset_busy", 64'(busy), 64'(0));
    check_pmu();
    ARESETn = 1'b1;
    idle_cycles(2);

    send_pkt(3, 4, 0, -1, -1);
    idle_cycles(1);
    check_pmu();

    send_pkt(7, 3, 0, -1, -1);
    idle_cycles(1);
    send_pkt(5, 1, 0, -1, -1);
    idle_cycles(1);

    send_pkt(1, 1, 0, -1, -1);
    send_pkt(2, 1, 0, -1, -1);
    idle_cycles(1);
    check_pmu();

    send_pkt(0, 5, 1, -1, -1);
    idle_cycles(1);
    check_pmu();

    send_pkt(2, 6, 0, -1, 3);
    send_pkt(4, 2, 0, -1, -1);
    idle_cycles(1);
    check_pmu();

    send_pkt(2, 70, 0, -1, -1);
    idle_cycles(1);
    check_pmu();
    send_pkt(2, 4, 0, 1, -1);
    idle_cycles(1);
    check_pmu();

    for (int k = 0; k < 60; k++) begin
      int d;
      int l;
      int cb;
      d  = int'($urandom_range(0, 15));
      l  = int'($urandom_range(1, 8));
      cb = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, l - 1)) : -1;
      send_pkt(d, l, 2, cb, -1);
      idle_cycles(int'($urandom_range(0, 2)));
    end
    idle_cycles(1);
    check_pmu();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axis_demux_route_ctrl.md
# axis_demux_route_ctrl

Packet-level routing controller for the AXI-Stream channel demultiplexer in each NoC router port. Monitors the incoming stream, decodes the destination from the first beat's TDEST and drives the demux `en`/`ctrl` inputs, holding the route until the TLAST handshake. Optionally keeps per-channel packet and beat counters for the built-in PMU.

## Interface
- CHANNEL_NUMBER, 5, demux output channel count
- CHANNEL_NUMBER_WIDTH, $clog2(CHANNEL_NUMBER), width of `ctrl`
- DEST_WIDTH, 4, TDEST width
- DEFAULT_CHANNEL, 0, channel used for out-of-range TDEST
- CNT_WIDTH, 32, PMU counter width

- ACLK  input  1  clock
- ARESETn  input  1  asynchronous active-low reset
- in_tvalid  input  1  upstream TVALID
- in_tready  input  1  TREADY returned through the demux (`in.TREADY`)
- in_tlast  input  1  upstream TLAST (tie 1 for single-beat traffic)
- in_tdest  input  DEST_WIDTH  upstream TDEST
- en  output  1  demux enable; integration gates `in.TVALID`/`in.TREADY` with it
- ctrl  output  CHANNEL_NUMBER_WIDTH  demux channel select
- route_err  output  1  one-cycle pulse: out-of-range TDEST latched
- busy  output  1  packet in flight
- pmu_pkt_cnt  output  CNT_WIDTH×CHANNEL_NUMBER  packets completed per channel (ROUTE_PMU_EN only)
- pmu_beat_cnt  output  CNT_WIDTH×CHANNEL_NUMBER  beats transferred per channel (ROUTE_PMU_EN only)
- pmu_clear  input  1  synchronous counter clear (ROUTE_PMU_EN only)

## Operation
- States: IDLE, ROUTE.
- IDLE: en=0, busy=0, ctrl holds last value. On in_tvalid=1: latch ch = in_tdest if in_tdest < CHANNEL_NUMBER, else DEFAULT_CHANNEL and pulse route_err; go to ROUTE.
- ROUTE: en=1, busy=1, ctrl=latched ch, stable for the whole packet. Beat = in_tvalid & in_tready & en. Beat with in_tlast=1 → IDLE.
- TDEST on beats after the first is ignored; a mid-packet TDEST change does not re-route.
- in_tvalid dropping mid-packet (bubbles) keeps ROUTE; no timeout.
- Comparison uses full DEST_WIDTH; no truncation before the range check.

## Timing
- Reset values: en=0, ctrl=0, route_err=0, busy=0, state=IDLE, all PMU counters 0.
- Route latency: TVALID seen in IDLE at cycle N → en=1, ctrl valid at N+1; first handshake no earlier than N+1.
- TLAST beat at cycle M → en=0 at M+1; next packet routed at M+2 earliest. One-cycle bubble between back-to-back packets is required.
- Single-beat packet: TVALID at N, handshake at N+1, en=0 at N+2.
- route_err high exactly one cycle (N+1) with en.
- en and ctrl are registered; no combinational path from inputs to outputs.
- Async reset mid-packet: immediate return to IDLE, en=0; packet remainder is dropped by the integration, not reconstructed.

## Configuration
- ROUTE_PMU_EN defined: per-channel pkt/beat counters. Beat on channel ctrl increments pmu_beat_cnt[ctrl]; TLAST beat also increments pmu_pkt_cnt[ctrl]. Counters saturate at all-ones. pmu_clear zeroes all next cycle; clear wins over a simultaneous increment.
- Undefined: PMU ports and counters absent; routing behaviour identical.

## Structure
- Package axis_route_pkg: state enum (ROUTE_IDLE, ROUTE_ACTIVE), saturating-increment function, default widths.
- Sub-module axis_route_pmu: the saturating counter bank, instantiated only under ROUTE_PMU_EN.

## Test plan
- 4-beat packet, TDEST=3, TREADY=1: en rises 1 cycle after TVALID, ctrl=3 for all 4 beats, en=0 the cycle after TLAST beat; pmu_beat_cnt[3]=4, pmu_pkt_cnt[3]=1.
- TDEST=7 with CHANNEL_NUMBER=5: ctrl=DEFAULT_CHANNEL(0), route_err pulses once, packet completes on channel 0.
- Back-to-back single-beat packets TDEST=1 then 2: ctrl 1 then 2, one idle cycle between, no beat lost or duplicated.
- TDEST changed 0→4 on beat 2 with TREADY toggling 1/0: ctrl stays 0 throughout; beat count equals handshakes only.
- ARESETn pulsed mid-packet: en=0, ctrl=0, busy=0 immediately; next packet routes normally.
- Counter at all-ones receives beat → stays all-ones; pmu_clear with simultaneous beat → counter reads 0.
